// File: rtl/fire_control.sv
// fire_control: initiator side of the shot interface for one player.
// Latches the ship layout, turns keypad row/column selections into a one-hot
// target, fires, waits a fixed response latency, then records the hit/miss
// result and tracks shot history, counters and win/lose status.
module fire_control #(
   parameter int RESP_LAT  = 2,   // cycles from the fire pulse to the sampled result (1..7)
   parameter int MAX_SHOTS = 20   // shot limit; reaching it without a win means lose (1..36)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [35:0] ship_layout,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        hit_in,
   input  logic        miss_in,
   output logic        place,
   output logic [35:0] ships_out,
   output logic        fire,
   output logic [35:0] target,
   output logic        last_hit,
   output logic        last_miss,
   output logic [5:0]  shots,
   output logic [5:0]  hits,
   output logic        key_err,
   output logic        win,
   output logic        lose,
   output logic        busy
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PLACE   = 3'd1,
      ST_AIM     = 3'd2,
      ST_FIRE    = 3'd3,
      ST_WAIT    = 3'd4,
      ST_RESOLVE = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   localparam logic [2:0] LAT_INIT_C  = 3'(RESP_LAT - 1);
   localparam logic [5:0] MAX_SHOTS_C = 6'(MAX_SHOTS);

   localparam logic [3:0] KEY_FIRE_C  = 4'hC;
   localparam logic [3:0] KEY_CLEAR_C = 4'hD;

   // Number of ship cells in a layout (0..36 fits in 6 bits).
   function automatic logic [5:0] popcount36(input logic [35:0] v);
      logic [5:0] n;
      n = 6'd0;
      for (int i = 0; i < 36; i++) begin
         n = n + {5'd0, v[i]};
      end
      return n;
   endfunction

   // Column key 0x6..0xB maps to column index 0..5.
   function automatic logic [2:0] col_of(input logic [3:0] code);
      logic [2:0] c;
      case (code)
         4'h6:    c = 3'd0;
         4'h7:    c = 3'd1;
         4'h8:    c = 3'd2;
         4'h9:    c = 3'd3;
         4'hA:    c = 3'd4;
         4'hB:    c = 3'd5;
         default: c = 3'd0;
      endcase
      return c;
   endfunction

   state_t      state_r;
   state_t      next_s;
   logic [35:0] history_r;
   logic [5:0]  ship_cells_r;
   logic [2:0]  row_sel_r;
   logic [2:0]  col_sel_r;
   logic        row_v_r;
   logic        col_v_r;
   logic [5:0]  idx_r;
   logic [2:0]  cnt_r;

   logic [5:0]  layout_pop_s;
   logic        start_legal_s;
   logic        start_ok_s;
   logic        start_bad_s;
   logic        aim_key_s;
   logic        key_row_s;
   logic        key_col_s;
   logic        key_clear_s;
   logic        key_fire_s;
   logic [5:0]  sel_idx_s;
   logic        fire_ok_s;
   logic        fire_bad_s;
   logic [5:0]  shots_upd_s;
   logic [5:0]  hits_upd_s;
   logic        win_now_s;
   logic        lose_now_s;
   logic        place_d_s;
   logic        fire_d_s;
   logic        busy_d_s;
   logic        key_err_d_s;

   // miss_in is redundant with hit_in; the result is taken from hit_in alone.
   logic        unused_miss_s;
   assign unused_miss_s = miss_in;

   assign layout_pop_s  = popcount36(ship_layout);
   assign start_legal_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
   assign start_ok_s    = start_legal_s && start && (layout_pop_s != 6'd0);
   assign start_bad_s   = start_legal_s && start && (layout_pop_s == 6'd0);

   assign aim_key_s     = (state_r == ST_AIM) && key_valid;
   assign key_row_s     = aim_key_s && (key_code <= 4'h5);
   assign key_col_s     = aim_key_s && (key_code >= 4'h6) && (key_code <= 4'hB);
   assign key_clear_s   = aim_key_s && (key_code == KEY_CLEAR_C);
   assign key_fire_s    = aim_key_s && (key_code == KEY_FIRE_C);

   assign sel_idx_s     = ({3'd0, row_sel_r} * 6'd6) + {3'd0, col_sel_r};
   assign fire_ok_s     = key_fire_s && row_v_r && col_v_r && !history_r[sel_idx_s];
   assign fire_bad_s    = key_fire_s && !fire_ok_s;

   // Counts as they will be after the current RESOLVE cycle; the end-of-game
   // decision is made on these, with a win taking priority over a loss.
   assign shots_upd_s   = shots + 6'd1;
   assign hits_upd_s    = hits + {5'd0, hit_in};
   assign win_now_s     = (hits_upd_s == ship_cells_r);
   assign lose_now_s    = (shots_upd_s == MAX_SHOTS_C);

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state decode for the turn sequence.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_ok_s) next_s = ST_PLACE;
            else            next_s = ST_IDLE;
         end
         ST_PLACE: next_s = ST_AIM;
         ST_AIM: begin
            if (fire_ok_s) next_s = ST_FIRE;
            else           next_s = ST_AIM;
         end
         ST_FIRE: begin
            // With a one-cycle latency the result is due right after the fire cycle.
            if (LAT_INIT_C == 3'd0) next_s = ST_RESOLVE;
            else                    next_s = ST_WAIT;
         end
         ST_WAIT: begin
            // The counter reaches zero on this decrement: RESOLVE lands RESP_LAT cycles after FIRE.
            if (cnt_r <= 3'd1) next_s = ST_RESOLVE;
            else               next_s = ST_WAIT;
         end
         ST_RESOLVE: begin
            if (win_now_s)       next_s = ST_DONE;
            else if (lose_now_s) next_s = ST_DONE;
            else                 next_s = ST_AIM;
         end
         ST_DONE: begin
            if (start_ok_s) next_s = ST_PLACE;
            else            next_s = ST_DONE;
         end
         default: next_s = ST_IDLE;
      endcase
   end

   // Pulse and status values for the coming cycle, decoded from the next state.
   always_comb begin
      place_d_s   = 1'b0;
      fire_d_s    = 1'b0;
      busy_d_s    = 1'b0;
      key_err_d_s = start_bad_s || fire_bad_s;
      case (next_s)
         ST_PLACE:   place_d_s = 1'b1;
         ST_FIRE: begin
            fire_d_s = 1'b1;
            busy_d_s = 1'b1;
         end
         ST_WAIT:    busy_d_s = 1'b1;
         ST_RESOLVE: busy_d_s = 1'b1;
         default:    busy_d_s = 1'b0;
      endcase
   end

   // Register the pulse and status outputs so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!reset) begin
         place   <= 1'b0;
         fire    <= 1'b0;
         busy    <= 1'b0;
         key_err <= 1'b0;
      end else begin
         place   <= place_d_s;
         fire    <= fire_d_s;
         busy    <= busy_d_s;
         key_err <= key_err_d_s;
      end
   end

   // Game datapath: layout latch, selection, target, history, counters and result.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ships_out    <= 36'd0;
         ship_cells_r <= 6'd0;
         history_r    <= 36'd0;
         row_sel_r    <= 3'd0;
         col_sel_r    <= 3'd0;
         row_v_r      <= 1'b0;
         col_v_r      <= 1'b0;
         idx_r        <= 6'd0;
         cnt_r        <= 3'd0;
         target       <= 36'd0;
         last_hit     <= 1'b0;
         last_miss    <= 1'b0;
         shots        <= 6'd0;
         hits         <= 6'd0;
         win          <= 1'b0;
         lose         <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start_ok_s) begin
                  ships_out    <= ship_layout;
                  ship_cells_r <= layout_pop_s;
                  win          <= 1'b0;
                  lose         <= 1'b0;
               end
            end
            ST_PLACE: begin
               history_r <= 36'd0;
               shots     <= 6'd0;
               hits      <= 6'd0;
               last_hit  <= 1'b0;
               last_miss <= 1'b0;
               row_v_r   <= 1'b0;
               col_v_r   <= 1'b0;
            end
            ST_AIM: begin
               if (key_row_s) begin
                  row_sel_r <= key_code[2:0];
                  row_v_r   <= 1'b1;
               end else if (key_col_s) begin
                  col_sel_r <= col_of(key_code);
                  col_v_r   <= 1'b1;
               end else if (key_clear_s) begin
                  row_v_r   <= 1'b0;
                  col_v_r   <= 1'b0;
               end else if (fire_ok_s) begin
                  target    <= 36'd1 << sel_idx_s;
                  idx_r     <= sel_idx_s;
               end
            end
            ST_FIRE: begin
               history_r[idx_r] <= 1'b1;
               row_v_r          <= 1'b0;
               col_v_r          <= 1'b0;
               cnt_r            <= LAT_INIT_C;
            end
            ST_WAIT: begin
               cnt_r <= cnt_r - 3'd1;
            end
            ST_RESOLVE: begin
               last_hit  <= hit_in;
               last_miss <= ~hit_in;
               shots     <= shots_upd_s;
               hits      <= hits_upd_s;
               target    <= 36'd0;
               if (win_now_s) begin
                  win <= 1'b1;
               end else if (lose_now_s) begin
                  lose <= 1'b1;
               end
            end
            default: begin
               cnt_r <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: doc/fire_control.md
Name: fire_control

Overview:
- Initiator side of the shot interface. Owns the game turn sequence for one player.
- Latches the ship layout and issues a one-cycle place pulse. Turns decoded keypad row/column selections into a one-hot 36-bit target, then issues a one-cycle fire pulse.
- Waits a fixed response latency, samples the hit/miss result, and keeps shot history, counters and win/lose status.
- Sits between the keypad decoder and the hit-evaluation block.

Parameters:
- RESP_LAT, 2, cycles from the fire pulse to a valid hit_in/miss_in (1..7).
- MAX_SHOTS, 20, shot limit; reaching it without a win means lose (1..36).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-low
- start  in  1  single-cycle pulse: latch ship_layout and begin a game
- ship_layout  in  36  ship cells; bit index = row*6 + col (row A=0, col 1=0)
- key_valid  in  1  single-cycle strobe qualifying key_code
- key_code  in  4  0x0-0x5 = row A-F; 0x6-0xB = col 1-6; 0xC = fire; 0xD = clear selection; 0xE-0xF ignored
- hit_in  in  1  result from the hit-evaluation block
- miss_in  in  1  result from the hit-evaluation block
- place  out  1  one-cycle pulse, ships_out valid
- ships_out  out  36  latched layout, held stable until the next start
- fire  out  1  one-cycle pulse, target valid
- target  out  36  one-hot shot cell, held from fire until RESOLVE completes, then zero
- last_hit  out  1  result of the most recent shot
- last_miss  out  1  result of the most recent shot
- shots  out  6  shots resolved this game
- hits  out  6  hits resolved this game
- key_err  out  1  one-cycle pulse: rejected fire or rejected start
- win  out  1  level, held until reset or restart
- lose  out  1  level, held until reset or restart
- busy  out  1  high in FIRE, WAIT, RESOLVE

Behaviour:
- Reset (reset=0 at a clk edge) clears all outputs to 0 and all internal registers to 0: history, selection-valid flags, ship_cells. State goes to IDLE. Reset has priority in every state, including mid-WAIT.
- IDLE
  - On start with popcount(ship_layout) != 0: latch ship_layout into ships_out, store popcount in ship_cells (6 bits), go to PLACE.
  - On start with popcount 0: pulse key_err, stay in IDLE.
- PLACE: place=1 for exactly one cycle; clear history, shots, hits, last_hit, last_miss; go to AIM.
- AIM
  - Row key: row_sel = code, row_v=1. Column key: col_sel = code-6, col_v=1. A later key of the same kind overwrites the earlier one.
  - Clear key (0xD): row_v=col_v=0.
  - Fire key (0xC): accepted only if row_v && col_v && history[idx]==0, where idx = row_sel*6+col_sel. If accepted, load target = 1<<idx and go to FIRE.
  - Fire key otherwise: key_err pulse, stay in AIM, selection retained.
- FIRE: fire=1 for one cycle; set history[idx]; clear row_v and col_v; load the wait counter with RESP_LAT-1; go to WAIT.
- WAIT: decrement the counter each cycle; at 0 go to RESOLVE. RESOLVE is therefore sampled RESP_LAT cycles after the fire cycle.
- RESOLVE (one cycle)
  - last_hit = hit_in; last_miss = ~hit_in (miss_in only cross-checks).
  - shots += 1; hits += hit_in; target cleared to 0.
  - Next state is evaluated on the updated counts. If hits == ship_cells: win=1, go to DONE. Else if shots == MAX_SHOTS: lose=1, go to DONE. Else go to AIM. Win takes priority when both conditions hit on the same shot.
- DONE: outputs held. Start restarts exactly as in IDLE, clearing win and lose when the start is accepted.
- Ignored input: key_valid is ignored outside AIM; start is ignored outside IDLE and DONE.
- Counters are 6-bit and cannot wrap: MAX_SHOTS ≤ 36 and the history check bounds hits.
- Simultaneous key_valid and start in the same cycle: only the input legal in the current state acts.

Test Plan:
- Reset mid-WAIT, then release → all outputs 0; state IDLE; a fire key produces no fire; a start works normally.
- Layout bit 7 (B2) only; start → place pulse one cycle later with ships_out=0x000000080. Keys 0x1, 0x7, 0xC → fire pulse with target=0x000000080. hit_in=1 driven RESP_LAT=2 cycles after fire → last_hit=1, hits=1, shots=1, win=1, busy=0.
- Fire at A1 (keys 0x0, 0x6, 0xC), then again 0x0, 0x6, 0xC → second attempt gives key_err pulse, no fire, shots stays 1.
- Fire key with only a row selected; separately, row 0x2 then 0xD then col 0x6 then 0xC → key_err each time, no fire.
- MAX_SHOTS=3, layout one cell, three distinct misses → shots=3, lose=1, win=0. Then start → place pulse, shots=0, lose=0.
- Last ship cell hit on shot MAX_SHOTS → win=1, lose=0. A start with ship_layout=0 in IDLE → key_err, no place.
